// File: rtl/npu_pkg.sv
// +----------------------------------------------------------------------------+
// | npu_pkg: shared types, address map and requantisation helper for the MAC   |
// | engine.                                                      Revision: 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

package npu_pkg;

  typedef enum logic [1:0] {
    MODE_CONV_RELU = 2'd0,
    MODE_CONV_LIN  = 2'd1,
    MODE_FCN       = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [2:0] SEL_ACC  = 3'd0;
  localparam logic [2:0] SEL_IMG  = 3'd1;
  localparam logic [2:0] SEL_WGT  = 3'd2;
  localparam logic [2:0] SEL_FCNW = 3'd3;
  localparam logic [2:0] SEL_CTRL = 3'd4;
  localparam logic [2:0] SEL_STAT = 3'd5;
  localparam logic [2:0] SEL_RES  = 3'd6;
  localparam logic [2:0] SEL_FCNX = 3'd7;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_ACC  = 1;
  localparam int CTRL_CLR_WIN  = 2;
  localparam int CTRL_CLR_PACK = 3;
  localparam int CTRL_MODE_LO  = 4;
  localparam int CTRL_MODE_HI  = 5;
  localparam int CTRL_SHIFT_LO = 6;
  localparam int CTRL_SHIFT_HI = 10;

  function automatic int ncyc(input int n_elem, input int n_pe);
    return (n_elem + n_pe - 1) / n_pe;
  endfunction

  // Arithmetic shift, then clamp to unsigned [0,255] (relu) or signed [-128,127].
  function automatic logic [7:0] requant(input logic signed [31:0] v,
                                         input logic [4:0] sh,
                                         input logic relu);
    logic signed [31:0] y;
    y = v >>> sh;
    if (relu) begin
      if (y < 32'sd0) return 8'h00;
      if (y > 32'sd255) return 8'hFF;
    end else begin
      if (y < -32'sd128) return 8'h80;
      if (y > 32'sd127) return 8'h7F;
    end
    return 8'(y);
  endfunction

endpackage

`default_nettype wire

// File: rtl/npu_win_reg.sv
// +----------------------------------------------------------------------------+
// | npu_win_reg: K_H x K_W byte window, shifted one column left per load.      |
// | Elements are exported row-major as 9-bit signed values.      Revision: 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module npu_win_reg #(
  parameter int K_H       = 3,
  parameter int K_W       = 3,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   i_clr,
  input  logic                   i_shift,
  input  logic [8*K_H-1:0]       i_col,
  output logic [K_H*K_W*9-1:0]   o_elems
);

  localparam int N_ELEM = K_H * K_W;

  logic [N_ELEM*8-1:0] r_win;
  logic [N_ELEM*8-1:0] w_win_nxt;

  for (genvar r = 0; r < K_H; r++) begin : g_row
    for (genvar c = 0; c < K_W; c++) begin : g_col
      if (c < K_W - 1) begin : g_shift
        assign w_win_nxt[(r*K_W+c)*8 +: 8] = r_win[(r*K_W+c+1)*8 +: 8];
      end else begin : g_load
        assign w_win_nxt[(r*K_W+c)*8 +: 8] = i_col[r*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni || i_clr) begin
      r_win <= '0;
    end else if (i_shift) begin
      r_win <= w_win_nxt;
    end
  end

  for (genvar e = 0; e < N_ELEM; e++) begin : g_elem
    if (IS_SIGNED) begin : g_sext
      assign o_elems[e*9 +: 9] = {r_win[e*8+7], r_win[e*8 +: 8]};
    end else begin : g_zext
      assign o_elems[e*9 +: 9] = {1'b0, r_win[e*8 +: 8]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/npu_mac_engine.sv
// +----------------------------------------------------------------------------+
// | npu_mac_engine: bus-slave conv/FCN MAC engine with requantised byte pack.  |
// |                                                              Revision: 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module npu_mac_engine
  import npu_pkg::*;
#(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int NUM_PE = 4,
  parameter int ACC_W  = 24
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        ena,
  input  logic        wea,
  input  logic [15:0] addra,
  input  logic [31:0] dina,
  output logic [31:0] douta
);

  localparam int N_ELEM = K_H * K_W;
  localparam int NCYC   = ncyc(N_ELEM, NUM_PE);
  localparam int CW     = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_e                   r_state, w_state_nxt;
  mode_e                    r_mode;
  logic [4:0]               r_shift;
  logic [7:0]               r_fcn_x;
  logic [CW-1:0]            r_cyc;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_done, r_err;
  logic [2:0]               r_pack_cnt;
  logic [31:0]              r_pack;

  logic [2:0]  w_sel;
  logic        w_wr, w_rd, w_busy, w_ctrl, w_start_req, w_start;
  logic        w_clr_acc, w_clr_win, w_clr_pack, w_data_wr, w_conflict;
  logic        w_img_wr, w_wgt_wr, w_fcnw_wr, w_fcnx_wr, w_res_pop;
  mode_e       w_new_mode;
  logic [7:0]  w_byte;
  logic [12:0] w_unused_addr;

  assign w_sel         = addra[14:12];
  assign w_unused_addr = {addra[15], addra[11:0]};
  assign w_wr          = ena & wea;
  assign w_rd          = ena & ~wea;
  assign w_busy        = (r_state != ST_IDLE);
  assign w_ctrl        = w_wr && (w_sel == SEL_CTRL);
  assign w_new_mode    = mode_e'(dina[CTRL_MODE_HI:CTRL_MODE_LO]);
  assign w_clr_acc     = w_ctrl & dina[CTRL_CLR_ACC];
  assign w_clr_win     = w_ctrl & dina[CTRL_CLR_WIN];
  assign w_clr_pack    = w_ctrl & dina[CTRL_CLR_PACK];
  assign w_start_req   = w_ctrl & dina[CTRL_START];
  assign w_start       = w_start_req & ~w_busy & (w_new_mode != MODE_FCN);
  assign w_data_wr     = w_wr && ((w_sel == SEL_IMG) || (w_sel == SEL_WGT) ||
                                  (w_sel == SEL_FCNW) || (w_sel == SEL_FCNX));
  assign w_conflict    = w_busy & (w_data_wr | w_start_req);
  assign w_img_wr      = w_wr && (w_sel == SEL_IMG) && !w_busy;
  assign w_wgt_wr      = w_wr && (w_sel == SEL_WGT) && !w_busy;
  assign w_fcnw_wr     = w_wr && (w_sel == SEL_FCNW) && !w_busy;
  assign w_fcnx_wr     = w_wr && (w_sel == SEL_FCNX) && !w_busy;
  assign w_res_pop     = w_rd && (w_sel == SEL_RES) && (r_mode != MODE_FCN);
  assign w_byte        = requant(32'(r_acc), r_shift, r_mode == MODE_CONV_RELU);

  logic [N_ELEM*9-1:0] w_img_flat, w_wgt_flat;

  npu_win_reg #(.K_H(K_H), .K_W(K_W), .IS_SIGNED(1'b0)) u_img_win (
    .clk(clk), .rst_ni(rst_ni), .i_clr(w_clr_win), .i_shift(w_img_wr),
    .i_col(dina[8*K_H-1:0]), .o_elems(w_img_flat)
  );

  npu_win_reg #(.K_H(K_H), .K_W(K_W), .IS_SIGNED(1'b1)) u_wgt_win (
    .clk(clk), .rst_ni(rst_ni), .i_clr(w_clr_win), .i_shift(w_wgt_wr),
    .i_col(dina[8*K_H-1:0]), .o_elems(w_wgt_flat)
  );

  logic signed [8:0]       w_img [N_ELEM];
  logic signed [8:0]       w_wgt [N_ELEM];
  logic signed [ACC_W-1:0] w_prod [NCYC*4];
  logic signed [ACC_W-1:0] w_cycsum [NCYC];

  for (genvar e = 0; e < N_ELEM; e++) begin : g_unpack
    assign w_img[e] = w_img_flat[e*9 +: 9];
    assign w_wgt[e] = w_wgt_flat[e*9 +: 9];
  end

  // Lane slots are padded to four so every cycle sum is a fixed 4-input adder.
  for (genvar c = 0; c < NCYC; c++) begin : g_cyc
    for (genvar q = 0; q < 4; q++) begin : g_lane
      if ((q < NUM_PE) && (c*NUM_PE + q < N_ELEM)) begin : g_used
        logic signed [17:0] w_p;
        assign w_p = w_img[c*NUM_PE+q] * w_wgt[c*NUM_PE+q];
        assign w_prod[c*4+q] = ACC_W'(w_p);
      end else begin : g_idle
        assign w_prod[c*4+q] = '0;
      end
    end
    assign w_cycsum[c] = w_prod[c*4] + w_prod[c*4+1] + w_prod[c*4+2] + w_prod[c*4+3];
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_CALC;
      ST_CALC:   if (r_cyc == CW'(NCYC - 1)) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A conv-mode result read or clr_pack empties the buffer before any push.
  logic [2:0]  w_base_cnt, w_pack_cnt_nxt;
  logic [31:0] w_base_data, w_pack_nxt;
  logic        w_push_ovf;

  always_comb begin
    w_base_cnt     = (w_clr_pack | w_res_pop) ? 3'd0 : r_pack_cnt;
    w_base_data    = (w_clr_pack | w_res_pop) ? 32'd0 : r_pack;
    w_pack_cnt_nxt = w_base_cnt;
    w_pack_nxt     = w_base_data;
    w_push_ovf     = 1'b0;
    if (r_state == ST_FINISH) begin
      if (w_base_cnt == 3'd4) begin
        w_push_ovf = 1'b1;
      end else begin
        w_pack_nxt     = w_base_data | ({24'h0, w_byte} << {w_base_cnt[1:0], 3'b000});
        w_pack_cnt_nxt = w_base_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_mode     <= MODE_CONV_RELU;
      r_shift    <= '0;
      r_fcn_x    <= '0;
      r_cyc      <= '0;
      r_acc      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pack_cnt <= '0;
      r_pack     <= '0;
    end else begin
      if (w_ctrl) begin
        r_mode  <= w_new_mode;
        r_shift <= dina[CTRL_SHIFT_HI:CTRL_SHIFT_LO];
      end
      if (w_fcnx_wr) r_fcn_x <= dina[7:0];
      if (w_start)                   r_cyc <= '0;
      else if (r_state == ST_CALC)   r_cyc <= r_cyc + CW'(1);
      if (w_start || w_clr_acc)      r_acc <= '0;
      else if (r_state == ST_CALC)   r_acc <= r_acc + w_cycsum[r_cyc];
      if (w_start)                   r_done <= 1'b0;
      else if (r_state == ST_FINISH) r_done <= 1'b1;
      r_err      <= ((w_clr_pack ? 1'b0 : r_err) | w_conflict | w_push_ovf);
      r_pack_cnt <= w_pack_cnt_nxt;
      r_pack     <= w_pack_nxt;
    end
  end

  logic [31:0] w_fcn_word;

  for (genvar p = 0; p < 4; p++) begin : g_fcn
    if (p < NUM_PE) begin : g_used
      logic signed [ACC_W-1:0] r_lane_acc;
      logic signed [17:0]      w_p;
      assign w_p = $signed({1'b0, r_fcn_x}) * $signed({dina[8*p+7], dina[8*p +: 8]});
      always_ff @(posedge clk) begin
        if (!rst_ni || w_clr_acc) r_lane_acc <= '0;
        else if (w_fcnw_wr)       r_lane_acc <= r_lane_acc + ACC_W'(w_p);
      end
      assign w_fcn_word[8*p +: 8] = requant(32'(r_lane_acc), r_shift, 1'b1);
    end else begin : g_idle
      assign w_fcn_word[8*p +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      douta <= '0;
    end else if (w_rd) begin
      case (w_sel)
        SEL_ACC:  douta <= 32'(r_acc);
        SEL_STAT: douta <= {26'b0, r_pack_cnt, r_err, r_done, w_busy};
        SEL_RES:  douta <= (r_mode == MODE_FCN) ? w_fcn_word : r_pack;
        default:  douta <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_npu_mac_engine.sv
// +----------------------------------------------------------------------------+
// | tb_npu_mac_engine: scoreboard bench with a behavioural reference model.    |
// |                                                              Revision: 1.0 |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_npu_mac_engine;

  localparam int K_H    = 3;
  localparam int K_W    = 3;
  localparam int NUM_PE = 4;
  localparam int ACC_W  = 24;
  localparam int NCYC   = (K_H*K_W + NUM_PE - 1) / NUM_PE;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ena = 1'b0;
  logic        wea = 1'b0;
  logic [15:0] addra = '0;
  logic [31:0] dina = '0;
  logic [31:0] douta;

  npu_mac_engine #(.K_H(K_H), .K_W(K_W), .NUM_PE(NUM_PE), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_ni(rst_ni), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(douta)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q_exp[$];
  string       q_name[$];

  // Reference model state
  int         m_img[K_H][K_W];
  int         m_wgt[K_H][K_W];
  longint     m_acc;
  longint     m_lane[NUM_PE];
  int         m_mode, m_shift, m_fcnx;
  logic [7:0] m_pack[$];
  bit         m_err, m_done;

  function automatic longint wrap(input longint v);
    longint m;
    m = v & ((64'sd1 <<< ACC_W) - 1);
    if (m >= (64'sd1 <<< (ACC_W-1))) m = m - (64'sd1 <<< ACC_W);
    return m;
  endfunction

  function automatic logic [7:0] m_requant(input longint a, input int sh, input bit relu);
    longint y;
    y = a >>> sh;
    if (relu) begin
      if (y < 0) return 8'h00;
      if (y > 255) return 8'hFF;
    end else begin
      if (y < -128) return 8'h80;
      if (y > 127) return 8'h7F;
    end
    return 8'(y);
  endfunction

  function automatic logic [31:0] m_status(input bit busy);
    return {26'b0, 3'(m_pack.size()), m_err, m_done, busy};
  endfunction

  function automatic void m_reset();
    foreach (m_img[r, c]) begin m_img[r][c] = 0; m_wgt[r][c] = 0; end
    foreach (m_lane[p]) m_lane[p] = 0;
    m_acc = 0; m_mode = 0; m_shift = 0; m_fcnx = 0;
    m_pack.delete(); m_err = 0; m_done = 0;
  endfunction

  function automatic void m_ctrl(input logic [31:0] d);
    if (d[1]) begin m_acc = 0; foreach (m_lane[p]) m_lane[p] = 0; end
    if (d[2]) foreach (m_img[r, c]) begin m_img[r][c] = 0; m_wgt[r][c] = 0; end
    if (d[3]) begin m_pack.delete(); m_err = 0; end
    m_mode  = int'(d[5:4]);
    m_shift = int'(d[10:6]);
  endfunction

  function automatic void m_finish_conv();
    longint s = 0;
    foreach (m_img[r, c]) s += longint'(m_img[r][c]) * longint'(m_wgt[r][c]);
    m_acc = wrap(s);
    if (m_pack.size() == 4) m_err = 1;
    else m_pack.push_back(m_requant(m_acc, m_shift, m_mode == 0));
    m_done = 1;
  endfunction

  // Bus tasks: entered at a negedge, drive one transaction, return at the next negedge.
  task automatic bus_write(input logic [2:0] sel, input logic [31:0] d);
    ena = 1'b1; wea = 1'b1; addra = {1'b0, sel, 12'h000}; dina = d;
    @(negedge clk);
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] sel, input logic [31:0] exp, input string nm);
    ena = 1'b1; wea = 1'b0; addra = {1'b0, sel, 12'h000}; dina = $urandom;
    q_exp.push_back(exp);
    q_name.push_back(nm);
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic idle(input int n);
    ena = 1'b0; wea = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic load_img(input logic [31:0] d);
    bus_write(3'd1, d);
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W-1; c++) m_img[r][c] = m_img[r][c+1];
      m_img[r][K_W-1] = int'(d[8*r +: 8]);
    end
  endtask

  task automatic load_wgt(input logic [31:0] d);
    bus_write(3'd2, d);
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W-1; c++) m_wgt[r][c] = m_wgt[r][c+1];
      m_wgt[r][K_W-1] = int'($signed(d[8*r +: 8]));
    end
  endtask

  task automatic fill(input logic [31:0] img, input logic [31:0] wgt);
    for (int c = 0; c < K_W; c++) begin load_img(img); load_wgt(wgt); end
  endtask

  task automatic read_status(input string nm);
    bus_read(3'd5, m_status(1'b0), nm);
  endtask

  task automatic read_acc(input string nm);
    bus_read(3'd0, 32'(m_acc), nm);
  endtask

  task automatic read_res(input string nm);
    logic [31:0] w;
    w = '0;
    if (m_mode == 2) begin
      for (int p = 0; p < NUM_PE; p++) w[8*p +: 8] = m_requant(m_lane[p], m_shift, 1'b1);
    end else begin
      foreach (m_pack[i]) w[8*i +: 8] = m_pack[i];
      m_pack.delete();
    end
    bus_read(3'd6, w, nm);
  endtask

  // Start a conv and poll status every cycle until it reports completion.
  task automatic run_conv(input logic [31:0] ctrl);
    logic [31:0] pre;
    m_ctrl(ctrl);
    bus_write(3'd4, ctrl | 32'h1);
    m_done = 0;
    pre = m_status(1'b1);
    for (int k = 1; k <= NCYC + 1; k++) bus_read(3'd5, pre, "busy_window");
    m_finish_conv();
    bus_read(3'd5, m_status(1'b0), "done_status");
  endtask

  task automatic fcn_x(input logic [7:0] x);
    bus_write(3'd7, {$urandom_range(0, 255) << 24, 16'h0, x});
    m_fcnx = int'(x);
  endtask

  task automatic fcn_w(input logic [31:0] d);
    bus_write(3'd3, d);
    for (int p = 0; p < NUM_PE; p++)
      m_lane[p] = wrap(m_lane[p] + longint'(m_fcnx) * longint'($signed(d[8*p +: 8])));
  endtask

  function automatic logic [31:0] ctrl_word(input int mode, input int sh, input bit start);
    return 32'(start) | (32'(mode) << 4) | (32'(sh) << 6);
  endfunction

  // Scoreboard monitor: pops one expectation per read issued on the bus.
  initial begin
    logic [31:0] exp;
    string       nm;
    forever begin
      @(posedge clk);
      if (rst_ni && ena && !wea) begin
        #1;
        n_vec++;
        if (q_exp.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_read: douta=%08h required no read", douta);
        end else begin
          exp = q_exp.pop_front();
          nm  = q_name.pop_front();
          if (douta !== exp) begin
            n_err++;
            $display("FAIL %s: douta=%08h required %08h", nm, douta, exp);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d reads pending", q_exp.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          md;
    m_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    read_status("reset_status");
    read_acc("reset_acc");
    read_res("reset_result");

    // Small positive conv
    fill(32'hAB010101, 32'h00020202);
    run_conv(ctrl_word(0, 0, 1));
    read_acc("acc_ones_twos");
    read_res("result_ones_twos");
    read_status("pack_cleared");

    // Negative accumulator, relu then linear
    fill(32'h000A0A0A, 32'h55FFFFFF);
    run_conv(ctrl_word(0, 0, 1));
    run_conv(ctrl_word(1, 0, 1));
    read_acc("acc_neg90");
    read_res("result_relu_lin_neg");

    // Large accumulator with shift: saturate both ways
    fill(32'h00FFFFFF, 32'h007F7F7F);
    run_conv(ctrl_word(0, 4, 1));
    run_conv(ctrl_word(1, 4, 1));
    read_acc("acc_291465");
    read_res("result_saturate");

    // Pack overflow
    for (int i = 0; i < 5; i++) run_conv(ctrl_word(i % 2, 4, 1));
    read_res("result_overflow_first4");
    read_status("status_after_ovf_read");
    bus_write(3'd4, ctrl_word(0, 0, 0) | 32'h8);
    m_ctrl(ctrl_word(0, 0, 0) | 32'h8);
    read_status("status_after_clr_pack");

    // FCN mode
    d = ctrl_word(2, 0, 0) | 32'h2;
    bus_write(3'd4, d);
    m_ctrl(d);
    fcn_x(8'd3);
    fcn_w({8'd0, 8'd5, 8'hFE, 8'd1});
    fcn_x(8'd2);
    fcn_w({8'd7, 8'hFF, 8'd1, 8'd4});
    read_res("fcn_result");
    read_res("fcn_result_no_pop");
    bus_write(3'd4, ctrl_word(2, 0, 1));
    m_ctrl(ctrl_word(2, 0, 1));
    read_status("fcn_start_ignored");

    // Write while busy is dropped and flags err; the conv uses the old window
    d = ctrl_word(0, 0, 1);
    m_ctrl(d);
    bus_write(3'd4, d);
    m_done = 0;
    bus_write(3'd1, 32'h00636363);
    m_err = 1;
    idle(NCYC + 2);
    m_finish_conv();
    read_status("busy_write_err");
    read_acc("busy_write_ignored");
    read_res("busy_write_result");

    // Reset in the second CALC cycle
    d = ctrl_word(1, 2, 1);
    m_ctrl(d);
    bus_write(3'd4, d);
    idle(1);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    m_reset();
    read_status("status_after_mid_reset");
    read_acc("acc_after_mid_reset");
    read_res("result_after_mid_reset");

    // Randomised convs
    for (int i = 0; i < 30; i++) begin
      for (int c = 0; c < K_W; c++) begin load_img($urandom); load_wgt($urandom); end
      md = $urandom_range(0, 2);
      if (md == 2) md = 3;
      d = ctrl_word(md, $urandom_range(0, 12), 1);
      if ($urandom_range(0, 7) == 0) d = d | 32'h8;
      if ($urandom_range(0, 9) == 0) d = d | 32'h4;
      run_conv(d);
      if ($urandom_range(0, 2) == 0) read_acc("rand_acc");
      if ($urandom_range(0, 3) == 0) read_res("rand_result");
    end
    read_res("rand_final_result");

    // Randomised FCN rounds
    for (int i = 0; i < 5; i++) begin
      d = ctrl_word(2, $urandom_range(0, 5), 0) | 32'h2;
      bus_write(3'd4, d);
      m_ctrl(d);
      for (int j = 0; j < 6; j++) begin
        fcn_x(8'($urandom));
        fcn_w($urandom);
      end
      read_res("rand_fcn_result");
      read_acc("rand_fcn_acc");
      read_status("rand_fcn_status");
    end

    idle(3);
    n_vec++;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
